// File: rtl/axis_upsizer.sv
// Narrow-to-wide AXI-Stream packer: C_RATIO input beats become one output word,
// little-endian lane order; tlast (when enabled) flushes a partial word early.

module axis_upsizer_lane #(
  parameter int W    = 8,
  parameter int KW   = 1,
  parameter int IW   = 2,
  parameter int LANE = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [IW-1:0] idx,
  input  logic          acc,
  input  logic          clr,
  input  logic [W-1:0]  din,
  input  logic [KW-1:0] kin,
  output logic [W-1:0]  lane_d,
  output logic [KW-1:0] lane_k
);
  logic          sel;
  logic [W-1:0]  asm_d;
  logic [KW-1:0] asm_k;

  assign sel = (idx == IW'(LANE));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      asm_d <= '0;
      asm_k <= '0;
    end else if (acc && sel) begin
      asm_d <= din;
      asm_k <= kin;
    end
  end

  // The completing beat bypasses assembly straight into the output word.
  assign lane_d = sel ? din : asm_d;
  assign lane_k = sel ? kin : asm_k;
endmodule

module axis_upsizer #(
  parameter int C_IN_WIDTH = 8,
  parameter int C_RATIO    = 4,
  parameter int C_HAS_LAST = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [C_IN_WIDTH-1:0]             s_axis_tdata,
  input  logic [C_IN_WIDTH/8-1:0]           s_axis_tkeep,
  input  logic                              s_axis_tlast,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  output logic [C_IN_WIDTH*C_RATIO-1:0]     m_axis_tdata,
  output logic [C_IN_WIDTH*C_RATIO/8-1:0]   m_axis_tkeep,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tvalid,
  input  logic                              m_axis_tready
);
  localparam int KW = C_IN_WIDTH / 8;
  localparam int IW = $clog2(C_RATIO);
  localparam logic [IW-1:0] LAST_IDX = IW'(C_RATIO - 1);
  localparam bit HAS_LAST = (C_HAS_LAST != 0);

  logic [IW-1:0]                         idx;
  logic                                  acc, frame_end, complete;
  logic [C_RATIO-1:0][C_IN_WIDTH-1:0]    word_d, out_d;
  logic [C_RATIO-1:0][KW-1:0]            word_k, out_k;
  logic                                  out_last, out_vld;

  assign s_axis_tready = ~rst & (~out_vld | m_axis_tready);
  assign acc           = s_axis_tvalid & s_axis_tready;
  assign frame_end     = HAS_LAST & s_axis_tlast;
  assign complete      = acc & ((idx == LAST_IDX) | frame_end);

  for (genvar k = 0; k < C_RATIO; k++) begin : g_lane
    axis_upsizer_lane #(.W(C_IN_WIDTH), .KW(KW), .IW(IW), .LANE(k)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .idx    (idx),
      .acc    (acc),
      .clr    (complete),
      .din    (s_axis_tdata),
      .kin    (s_axis_tkeep),
      .lane_d (word_d[k]),
      .lane_k (word_k[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (complete) begin
      idx <= '0;
    end else if (acc) begin
      idx <= idx + 1'b1;
    end
  end

  // Reload wins over drain so back-to-back words never insert a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_d    <= '0;
      out_k    <= '0;
      out_last <= 1'b0;
      out_vld  <= 1'b0;
    end else if (complete) begin
      out_d    <= word_d;
      out_k    <= word_k;
      out_last <= frame_end;
      out_vld  <= 1'b1;
    end else if (m_axis_tready) begin
      out_vld  <= 1'b0;
    end
  end

  assign m_axis_tdata  = out_d;
  assign m_axis_tkeep  = out_k;
  assign m_axis_tlast  = out_last;
  assign m_axis_tvalid = out_vld;
endmodule

// File: tb/tb_axis_upsizer.sv
// Directed bench for axis_upsizer: one DUT with tlast flushing, one with tlast ignored.

module tb_axis_upsizer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_keep = 1'b0, s_last = 1'b0, s_valid = 1'b0, s2_valid = 1'b0;
  logic        s_ready, s2_ready;
  logic        m_ready = 1'b1, m2_ready = 1'b1;
  logic [31:0] m_data, m2_data;
  logic [3:0]  m_keep, m2_keep;
  logic        m_last, m_valid, m2_last, m2_valid;
  int          compared = 0, mismatched = 0;
  logic [36:0] got[$], got2[$];

  always #5 clk = ~clk;

  axis_upsizer #(.C_IN_WIDTH(8), .C_RATIO(4), .C_HAS_LAST(1)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .m_axis_tdata(m_data), .m_axis_tkeep(m_keep), .m_axis_tlast(m_last),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready)
  );

  axis_upsizer #(.C_IN_WIDTH(8), .C_RATIO(4), .C_HAS_LAST(0)) dut_nolast (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_data), .s_axis_tkeep(s_keep), .s_axis_tlast(s_last),
    .s_axis_tvalid(s2_valid), .s_axis_tready(s2_ready),
    .m_axis_tdata(m2_data), .m_axis_tkeep(m2_keep), .m_axis_tlast(m2_last),
    .m_axis_tvalid(m2_valid), .m_axis_tready(m2_ready)
  );

  // Inputs only change #1 after posedge, so negedge sees the values the next edge will use.
  always @(negedge clk) begin
    if (m_valid && m_ready)   got.push_back({m_last, m_keep, m_data});
    if (m2_valid && m2_ready) got2.push_back({m2_last, m2_keep, m2_data});
  end

  task automatic send(input bit sel, input logic [7:0] d, input logic k, input logic l);
    int t = 0;
    s_data = d; s_keep = k; s_last = l;
    if (sel) s2_valid = 1'b1; else s_valid = 1'b1;
    @(negedge clk);
    while (!(sel ? s2_ready : s_ready) && t < 40) begin @(negedge clk); t++; end
    if (t >= 40) begin compared++; mismatched++; $display("FAIL send_timeout beat %h: ready stayed 0, want 1", d); end
    @(posedge clk); #1;
    s_valid = 1'b0; s2_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    compared++; if ({m_valid, m_last, m_keep, m_data} !== 38'h0) begin mismatched++; $display("FAIL reset_outputs got %h want 0", {m_valid, m_last, m_keep, m_data}); end
    compared++; if (s_ready !== 1'b0) begin mismatched++; $display("FAIL reset_ready got %b want 0", s_ready); end
    rst = 1'b0; #1;
    compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL ready_after_reset got %b want 1", s_ready); end
  endtask

  task automatic test_full_word();
    got.delete(); m_ready = 1'b1;
    send(0, 8'h11, 1'b1, 1'b0); send(0, 8'h22, 1'b1, 1'b0);
    send(0, 8'h33, 1'b1, 1'b0);
    compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL full_early_valid got %b want 0", m_valid); end
    send(0, 8'h44, 1'b1, 1'b1);
    compared++; if (m_valid !== 1'b1) begin mismatched++; $display("FAIL full_latency valid got %b want 1", m_valid); end
    compared++; if ({m_last, m_keep, m_data} !== {1'b1, 4'hF, 32'h44332211}) begin mismatched++; $display("FAIL full_word got %h want %h", {m_last, m_keep, m_data}, {1'b1, 4'hF, 32'h44332211}); end
    repeat (3) @(posedge clk); #1;
    compared++; if (got.size() != 1 || m_valid !== 1'b0) begin mismatched++; $display("FAIL full_count got %0d words valid %b want 1 word valid 0", got.size(), m_valid); end
  endtask

  task automatic test_short_frame();
    send(0, 8'hA1, 1'b1, 1'b0); send(0, 8'hA2, 1'b1, 1'b0); send(0, 8'hA3, 1'b1, 1'b1);
    compared++; if ({m_valid, m_last, m_keep, m_data} !== {1'b1, 1'b1, 4'h7, 32'h00A3A2A1}) begin mismatched++; $display("FAIL short_frame got %h want %h", {m_valid, m_last, m_keep, m_data}, {1'b1, 1'b1, 4'h7, 32'h00A3A2A1}); end
  endtask

  task automatic test_single_beat();
    send(0, 8'h5A, 1'b1, 1'b1);
    compared++; if ({m_valid, m_last, m_keep, m_data} !== {1'b1, 1'b1, 4'h1, 32'h0000005A}) begin mismatched++; $display("FAIL single_beat got %h want %h", {m_valid, m_last, m_keep, m_data}, {1'b1, 1'b1, 4'h1, 32'h0000005A}); end
  endtask

  task automatic test_zero_keep();
    send(0, 8'h00, 1'b0, 1'b0); send(0, 8'h55, 1'b1, 1'b1);
    compared++; if ({m_last, m_keep, m_data} !== {1'b1, 4'h2, 32'h00005500}) begin mismatched++; $display("FAIL zero_keep_lane got %h want %h", {m_last, m_keep, m_data}, {1'b1, 4'h2, 32'h00005500}); end
    repeat (2) @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    got.delete(); m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(0, 8'(i), 1'b1, 1'b0);
    compared++; if (s_ready !== 1'b0) begin mismatched++; $display("FAIL bp_ready_after_4 got %b want 0", s_ready); end
    s_data = 8'h05; s_keep = 1'b1; s_last = 1'b0; s_valid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      compared++; if ({s_ready, m_valid, m_data} !== {1'b0, 1'b1, 32'h04030201}) begin mismatched++; $display("FAIL bp_hold cycle %0d got %h want %h", c, {s_ready, m_valid, m_data}, {1'b0, 1'b1, 32'h04030201}); end
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    for (int i = 5; i <= 8; i++) send(0, 8'(i), 1'b1, 1'b0);
    repeat (3) @(posedge clk); #1;
    compared++; if (got.size() != 2) begin mismatched++; $display("FAIL bp_count got %0d want 2", got.size()); end
    else begin
      compared++; if (got[0] !== {1'b0, 4'hF, 32'h04030201}) begin mismatched++; $display("FAIL bp_word0 got %h want %h", got[0], {1'b0, 4'hF, 32'h04030201}); end
      compared++; if (got[1] !== {1'b0, 4'hF, 32'h08070605}) begin mismatched++; $display("FAIL bp_word1 got %h want %h", got[1], {1'b0, 4'hF, 32'h08070605}); end
    end
  endtask

  task automatic test_back_to_back();
    got.delete(); m_ready = 1'b1;
    send(0, 8'hC1, 1'b1, 1'b1);
    send(0, 8'hC2, 1'b1, 1'b1);
    compared++; if ({m_valid, m_data} !== {1'b1, 32'h000000C2}) begin mismatched++; $display("FAIL b2b_second got %h want %h", {m_valid, m_data}, {1'b1, 32'h000000C2}); end
    send(0, 8'hC3, 1'b1, 1'b1);
    compared++; if ({m_valid, m_data} !== {1'b1, 32'h000000C3}) begin mismatched++; $display("FAIL b2b_third got %h want %h", {m_valid, m_data}, {1'b1, 32'h000000C3}); end
    repeat (2) @(posedge clk); #1;
    compared++; if (got.size() != 3) begin mismatched++; $display("FAIL b2b_count got %0d want 3", got.size()); end
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    send(0, 8'h31, 1'b1, 1'b1);
    compared++; if (m_valid !== 1'b1) begin mismatched++; $display("FAIL rst_pending valid got %b want 1", m_valid); end
    rst = 1'b1; #1;
    compared++; if (s_ready !== 1'b0) begin mismatched++; $display("FAIL rst_ready got %b want 0", s_ready); end
    @(posedge clk); #1;
    compared++; if ({m_valid, m_last, m_keep, m_data} !== 38'h0) begin mismatched++; $display("FAIL rst_outputs got %h want 0", {m_valid, m_last, m_keep, m_data}); end
    rst = 1'b0; got.delete(); m_ready = 1'b1;
    send(0, 8'hAA, 1'b1, 1'b0); send(0, 8'hBB, 1'b1, 1'b0);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    for (int i = 1; i <= 4; i++) send(0, 8'(i), 1'b1, 1'b0);
    repeat (3) @(posedge clk); #1;
    compared++; if (got.size() != 1) begin mismatched++; $display("FAIL rst_count got %0d want 1", got.size()); end
    else begin
      compared++; if (got[0] !== {1'b0, 4'hF, 32'h04030201}) begin mismatched++; $display("FAIL rst_word got %h want %h", got[0], {1'b0, 4'hF, 32'h04030201}); end
    end
  endtask

  task automatic test_no_last();
    logic [11:0] lpat = 12'b1011_0010_0110;
    got2.delete(); m2_ready = 1'b1;
    for (int i = 0; i < 12; i++) send(1, 8'(i + 1), 1'b1, lpat[i]);
    repeat (3) @(posedge clk); #1;
    compared++; if (got2.size() != 3) begin mismatched++; $display("FAIL nolast_count got %0d want 3", got2.size()); end
    else begin
      compared++; if (got2[0] !== {1'b0, 4'hF, 32'h04030201}) begin mismatched++; $display("FAIL nolast_word0 got %h want %h", got2[0], {1'b0, 4'hF, 32'h04030201}); end
      compared++; if (got2[1] !== {1'b0, 4'hF, 32'h08070605}) begin mismatched++; $display("FAIL nolast_word1 got %h want %h", got2[1], {1'b0, 4'hF, 32'h08070605}); end
      compared++; if (got2[2] !== {1'b0, 4'hF, 32'h0C0B0A09}) begin mismatched++; $display("FAIL nolast_word2 got %h want %h", got2[2], {1'b0, 4'hF, 32'h0C0B0A09}); end
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_short_frame();
    test_single_beat();
    test_zero_keep();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_no_last();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end
endmodule
